// File: rtl/uart_frame_tx.sv
// -----------------------------------------------------------------------------
// uart_frame_tx
//   Framed UART transmitter. A start request accepted in IDLE snapshots the
//   payload vector and sends SYNC_BYTE, the NBYTES payload bytes (byte 0
//   first) and an XOR checksum of the payload bytes. Each byte is start bit,
//   8 data bits LSB first, optional parity, then 1 or 2 stop bits. Bytes are
//   back-to-back. After the frame the line is held idle for GAP_CYCLES cycles
//   before a new request is accepted.
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   start        frame request, sampled only in IDLE
//   payload      NBYTES*8 bits, byte i at [8*i+7:8*i], captured on accept
//   busy         high from the cycle after accept through the end of the gap
//   done         one-cycle pulse when the checksum byte's last stop bit ends
//   tx           serial line, idle high, registered
//   frame_count  completed frames, wraps at 16 bits
// -----------------------------------------------------------------------------
module uart_frame_tx #(
  parameter int          CLK_FREQ   = 50_000_000,
  parameter int          BAUD       = 115_200,
  parameter int          NBYTES     = 9,
  parameter logic [7:0]  SYNC_BYTE  = 8'hAA,
  parameter int          PARITY     = 0,
  parameter int          STOP_BITS  = 1,
  parameter int          GAP_CYCLES = 50_000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [NBYTES*8-1:0] payload,
  output logic                busy,
  output logic                done,
  output logic                tx,
  output logic [15:0]         frame_count
);

  localparam int BIT_CYCLES = CLK_FREQ / BAUD;
  localparam int BW         = $clog2(NBYTES + 2);

  localparam logic [BW-1:0] LAST_IDX   = BW'(NBYTES + 1);
  localparam logic [31:0]   BIT_RELOAD = 32'(BIT_CYCLES - 1);
  localparam logic [31:0]   GAP_RELOAD = 32'(GAP_CYCLES - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_PAR   = 3'd3;
  localparam logic [2:0] S_STOP  = 3'd4;
  localparam logic [2:0] S_GAP   = 3'd5;

  // Elaboration-time parameter checks.
  if (NBYTES < 1 || NBYTES > 32) begin : g_bad_nbytes
    $error("uart_frame_tx: NBYTES must be 1..32");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_frame_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_frame_tx: STOP_BITS must be 1 or 2");
  end
  if (BIT_CYCLES < 2) begin : g_bad_baud
    $error("uart_frame_tx: CLK_FREQ/BAUD must be >= 2");
  end

  logic [2:0]          state;
  logic [31:0]         cnt;       // bit timer, reused as gap counter
  logic [2:0]          bit_idx;
  logic                stop_idx;
  logic [BW-1:0]       byte_idx;
  logic [7:0]          shreg;
  logic                par_bit;
  logic [7:0]          chk;
  logic [NBYTES*8-1:0] snapshot;
  logic [7:0]          cur_byte;
  int                  pay_sel;

  wire bit_end = (cnt == 32'd0);

  // Byte to be sent for the current byte_idx. The checksum slot reads chk,
  // which by then has folded in every payload byte as it was loaded.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    cur_byte = chk;
    pay_sel  = int'(byte_idx) - 1;
    if (byte_idx == '0) begin
      cur_byte = SYNC_BYTE;
    end else if (byte_idx != LAST_IDX) begin
      cur_byte = snapshot[8*pay_sel +: 8];
    end
  end

  // NOTE: the snapshot is pure datapath and is always overwritten on accept,
  // so it carries no reset.
  always_ff @(posedge clk) begin
    if (start && state == S_IDLE && !reset) begin
      snapshot <= payload;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      tx          <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      frame_count <= 16'd0;
      cnt         <= 32'd0;
      bit_idx     <= 3'd0;
      stop_idx    <= 1'b0;
      byte_idx    <= '0;
      shreg       <= 8'd0;
      par_bit     <= 1'b0;
      chk         <= 8'd0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          tx <= 1'b1;
          if (start) begin
            chk      <= 8'd0;
            byte_idx <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            cnt      <= BIT_RELOAD;
            state    <= S_START;
          end
        end

        // Byte is loaded at the end of its start bit so the checksum slot
        // sees chk after the last payload byte has been folded in.
        S_START: begin
          if (bit_end) begin
            shreg   <= cur_byte;
            par_bit <= (PARITY == 2) ? ~(^cur_byte) : ^cur_byte;
            if (byte_idx != '0 && byte_idx != LAST_IDX) begin
              chk <= chk ^ cur_byte;
            end
            tx      <= cur_byte[0];
            bit_idx <= 3'd0;
            cnt     <= BIT_RELOAD;
            state   <= S_DATA;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            cnt <= BIT_RELOAD;
            if (bit_idx == 3'd7) begin
              if (PARITY != 0) begin
                tx    <= par_bit;
                state <= S_PAR;
              end else begin
                tx       <= 1'b1;
                stop_idx <= 1'b0;
                state    <= S_STOP;
              end
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= shreg[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        S_PAR: begin
          if (bit_end) begin
            cnt      <= BIT_RELOAD;
            tx       <= 1'b1;
            stop_idx <= 1'b0;
            state    <= S_STOP;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        S_STOP: begin
          if (bit_end) begin
            if (STOP_BITS == 2 && !stop_idx) begin
              stop_idx <= 1'b1;
              cnt      <= BIT_RELOAD;
            end else if (byte_idx == LAST_IDX) begin
              done        <= 1'b1;
              frame_count <= frame_count + 16'd1;
              tx          <= 1'b1;
              if (GAP_CYCLES == 0) begin
                busy  <= 1'b0;
                state <= S_IDLE;
              end else begin
                cnt   <= GAP_RELOAD;
                state <= S_GAP;
              end
            end else begin
              byte_idx <= byte_idx + 1'b1;
              tx       <= 1'b0;
              cnt      <= BIT_RELOAD;
              state    <= S_START;
            end
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        S_GAP: begin
          tx <= 1'b1;
          if (bit_end) begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - 32'd1;
          end
        end

        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_frame_tx.sv
// -----------------------------------------------------------------------------
// tb_uart_frame_tx
//   Directed bench for uart_frame_tx with BIT_CYCLES = 4. Five instances cover
//   the parity, stop-bit, gap and frame-size variants. A line monitor samples
//   every bit at a fixed offset from the first falling edge of the frame, so
//   bit timing, byte spacing and the done position are all checked together.
// -----------------------------------------------------------------------------
module tb_uart_frame_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance map: 0 NB2/none/1stop/gap10, 1 NB2/even, 2 NB2/odd,
  //               3 NB2/none/2stop, 4 NB32/none/1stop/gap3
  logic         reset_v [5];
  logic         start_v [5];
  logic         busy_v  [5];
  logic         done_v  [5];
  logic         tx_v    [5];
  logic [15:0]  fc_v    [5];
  logic [15:0]  pay2    [4];
  logic [255:0] pay32;

  uart_frame_tx #(.CLK_FREQ(4), .BAUD(1), .NBYTES(2), .PARITY(0), .STOP_BITS(1), .GAP_CYCLES(10))
    u_p0 (.clk(clk), .reset(reset_v[0]), .start(start_v[0]), .payload(pay2[0]),
          .busy(busy_v[0]), .done(done_v[0]), .tx(tx_v[0]), .frame_count(fc_v[0]));
  uart_frame_tx #(.CLK_FREQ(4), .BAUD(1), .NBYTES(2), .PARITY(1), .STOP_BITS(1), .GAP_CYCLES(0))
    u_pe (.clk(clk), .reset(reset_v[1]), .start(start_v[1]), .payload(pay2[1]),
          .busy(busy_v[1]), .done(done_v[1]), .tx(tx_v[1]), .frame_count(fc_v[1]));
  uart_frame_tx #(.CLK_FREQ(4), .BAUD(1), .NBYTES(2), .PARITY(2), .STOP_BITS(1), .GAP_CYCLES(0))
    u_po (.clk(clk), .reset(reset_v[2]), .start(start_v[2]), .payload(pay2[2]),
          .busy(busy_v[2]), .done(done_v[2]), .tx(tx_v[2]), .frame_count(fc_v[2]));
  uart_frame_tx #(.CLK_FREQ(4), .BAUD(1), .NBYTES(2), .PARITY(0), .STOP_BITS(2), .GAP_CYCLES(0))
    u_s2 (.clk(clk), .reset(reset_v[3]), .start(start_v[3]), .payload(pay2[3]),
          .busy(busy_v[3]), .done(done_v[3]), .tx(tx_v[3]), .frame_count(fc_v[3]));
  uart_frame_tx #(.CLK_FREQ(4), .BAUD(1), .NBYTES(32), .PARITY(0), .STOP_BITS(1), .GAP_CYCLES(3))
    u_n32 (.clk(clk), .reset(reset_v[4]), .start(start_v[4]), .payload(pay32),
           .busy(busy_v[4]), .done(done_v[4]), .tx(tx_v[4]), .frame_count(fc_v[4]));

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Monitor results
  logic [7:0] cap_data [34];
  logic       cap_par  [34];
  logic       line_bits [408];
  int         cap_ferr, cap_done_at, cap_wait;
  logic       cap_timeout;

  // Called on a negedge. Waits for the line to fall, then samples each bit
  // one cycle into its 4-cycle slot. cap_wait is the number of negedges the
  // line stayed high before the frame; cap_done_at is the negedge index
  // (0 = first low sample) where done was first seen.
  task automatic capture(input int inst, input int nbytes, input int par, input int stops);
    int bpb, nbits, w, base;
    bpb   = 9 + ((par != 0) ? 1 : 0) + stops;
    nbits = (nbytes + 2) * bpb;
    cap_timeout = 1'b0;
    w = 0;
    while (tx_v[inst] && w < 3000) begin
      @(negedge clk);
      w++;
    end
    cap_wait = w;
    if (tx_v[inst]) begin
      cap_timeout = 1'b1;
      return;
    end
    cap_done_at = -1;
    cap_ferr    = 0;
    for (int c = 0; c <= nbits * 4; c++) begin
      if (c > 0) @(negedge clk);
      if (c % 4 == 1) line_bits[c/4] = tx_v[inst];
      if (done_v[inst] === 1'b1 && cap_done_at < 0) cap_done_at = c;
    end
    if (tx_v[inst] !== 1'b1) cap_ferr++;
    for (int b = 0; b < nbytes + 2; b++) begin
      base = b * bpb;
      if (line_bits[base] !== 1'b0) cap_ferr++;
      for (int k = 0; k < 8; k++) cap_data[b][k] = line_bits[base + 1 + k];
      cap_par[b] = (par != 0) ? line_bits[base + 9] : 1'b0;
      for (int s = 0; s < stops; s++)
        if (line_bits[base + 9 + ((par != 0) ? 1 : 0) + s] !== 1'b1) cap_ferr++;
    end
  endtask

  // Checks a 4-byte (NBYTES=2) frame.
  task automatic check_frame4(input string tag, input logic [31:0] exp_bytes, input int exp_done);
    check({tag, "_timeout"}, 32'(cap_timeout), 32'd0);
    check({tag, "_framing"}, 32'(cap_ferr), 32'd0);
    check({tag, "_bytes"}, {cap_data[0], cap_data[1], cap_data[2], cap_data[3]}, exp_bytes);
    check({tag, "_done_at"}, 32'(cap_done_at), 32'(exp_done));
  endtask

  task automatic pulse(input int inst);
    start_v[inst] = 1'b1;
    @(negedge clk);
    start_v[inst] = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int inst);
    int w;
    w = 0;
    while (busy_v[inst] && w < 200) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_idle"}, 32'(busy_v[inst]), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    logic [7:0] acc;
    for (int i = 0; i < 5; i++) begin
      reset_v[i] = 1'b1;
      start_v[i] = 1'b0;
    end
    for (int i = 0; i < 4; i++) pay2[i] = 16'h3412;
    pay32 = '0;
    repeat (3) @(negedge clk);

    // Reset state of every instance
    for (int i = 0; i < 5; i++) begin
      check($sformatf("rst%0d_tx", i), 32'(tx_v[i]), 32'd1);
      check($sformatf("rst%0d_busy", i), 32'(busy_v[i]), 32'd0);
      check($sformatf("rst%0d_done", i), 32'(done_v[i]), 32'd0);
      check($sformatf("rst%0d_fc", i), 32'(fc_v[i]), 32'd0);
      reset_v[i] = 1'b0;
    end
    @(negedge clk);

    // 1. Basic frame, 8N1: AA 12 34 26, done 160 cycles after first low
    pulse(0);
    check("t1_busy", 32'(busy_v[0]), 32'd1);
    capture(0, 2, 0, 1);
    check_frame4("t1", 32'hAA123426, 160);
    check("t1_fc", 32'(fc_v[0]), 32'd1);
    wait_idle("t1", 0);

    // 2. Even and odd parity
    pulse(1);
    capture(1, 2, 1, 1);
    check_frame4("t2e", 32'hAA123426, 176);
    check("t2e_par", {28'd0, cap_par[0], cap_par[1], cap_par[2], cap_par[3]}, 32'b0011);
    pulse(2);
    capture(2, 2, 2, 1);
    check_frame4("t2o", 32'hAA123426, 176);
    check("t2o_par", {28'd0, cap_par[0], cap_par[1], cap_par[2], cap_par[3]}, 32'b1100);

    // 3. Two stop bits: 11-bit bytes, 8 high cycles between bytes
    pulse(3);
    capture(3, 2, 0, 2);
    check_frame4("t3", 32'hAA123426, 176);

    // 4. start held, payload changed and start re-pulsed mid-frame
    @(negedge clk);
    pay2[0] = 16'h3412;
    start_v[0] = 1'b1;
    fork
      capture(0, 2, 0, 1);
      begin
        repeat (50) @(negedge clk);
        pay2[0] = 16'h7856;
        start_v[0] = 1'b0;
        @(negedge clk);
        start_v[0] = 1'b1;
      end
    join
    check_frame4("t4a", 32'hAA123426, 160);
    capture(0, 2, 0, 1);
    check_frame4("t4b", 32'hAA56782E, 160);
    check("t4_gap", 32'(cap_wait), 32'd11);
    start_v[0] = 1'b0;
    check("t4_fc", 32'(fc_v[0]), 32'd3);
    wait_idle("t4", 0);

    // 5. Reset during DATA of byte 1 (cycles 44..75 of the frame)
    pay2[0] = 16'h3412;
    pulse(0);
    repeat (50) @(negedge clk);
    reset_v[0] = 1'b1;
    @(negedge clk);
    check("t5_tx", 32'(tx_v[0]), 32'd1);
    check("t5_busy", 32'(busy_v[0]), 32'd0);
    check("t5_fc", 32'(fc_v[0]), 32'd0);
    @(negedge clk);
    reset_v[0] = 1'b0;
    bad = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (done_v[0] !== 1'b0 || tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0) bad++;
    end
    check("t5_quiet", 32'(bad), 32'd0);
    pay2[0] = 16'hC3F0;
    pulse(0);
    capture(0, 2, 0, 1);
    check_frame4("t5", 32'hAAF0C333, 160);
    check("t5_fc_after", 32'(fc_v[0]), 32'd1);
    wait_idle("t5", 0);

    // 6. NBYTES=32, zero payload, three back-to-back frames
    start_v[4] = 1'b1;
    for (int f = 1; f <= 3; f++) begin
      capture(4, 32, 0, 1);
      check($sformatf("t6f%0d_timeout", f), 32'(cap_timeout), 32'd0);
      check($sformatf("t6f%0d_framing", f), 32'(cap_ferr), 32'd0);
      check($sformatf("t6f%0d_sync", f), 32'(cap_data[0]), 32'hAA);
      acc = 8'd0;
      for (int b = 1; b <= 32; b++) acc = acc | cap_data[b];
      check($sformatf("t6f%0d_payload", f), 32'(acc), 32'd0);
      check($sformatf("t6f%0d_chk", f), 32'(cap_data[33]), 32'd0);
      check($sformatf("t6f%0d_done_at", f), 32'(cap_done_at), 32'd1360);
      check($sformatf("t6f%0d_fc", f), 32'(fc_v[4]), 32'(f));
      if (f > 1) check($sformatf("t6f%0d_gap", f), 32'(cap_wait), 32'd4);
    end
    start_v[4] = 1'b0;
    wait_idle("t6", 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
